// File: rtl/mips_alu_exec_pkg.sv
// Shared encodings for the MIPS EX-stage ALU: controller alu_op codes, funct
// codes, the internal operation enum and a rotate helper.
package mips_alu_pkg;

  localparam logic [4:0] ALUOP_RTYPE    = 5'd0;
  localparam logic [4:0] ALUOP_ADD      = 5'd1;
  localparam logic [4:0] ALUOP_AND      = 5'd2;
  localparam logic [4:0] ALUOP_OR       = 5'd3;
  localparam logic [4:0] ALUOP_XOR      = 5'd4;
  localparam logic [4:0] ALUOP_SLT      = 5'd5;
  localparam logic [4:0] ALUOP_SLTU     = 5'd6;
  localparam logic [4:0] ALUOP_LUI      = 5'd7;
  localparam logic [4:0] ALUOP_SPECIAL2 = 5'd8;
  localparam logic [4:0] ALUOP_SEXT     = 5'd9;
  localparam logic [4:0] ALUOP_SUB      = 5'd10;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_MOVN  = 6'h0B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [5:0] F2_MADD  = 6'h00;
  localparam logic [5:0] F2_MUL   = 6'h02;
  localparam logic [5:0] F2_MSUB  = 6'h04;

  localparam logic [4:0] SEL_SEB  = 5'h10;
  localparam logic [4:0] SEL_SEH  = 5'h18;

  typedef enum logic [4:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_ROTR, OP_SRA, OP_SLLV, OP_SRLV, OP_ROTRV, OP_SRAV,
    OP_PASSA, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_LUI, OP_MUL, OP_MADD, OP_MSUB, OP_SEB, OP_SEH
  } alu_op_e;

  // A count of 0 makes the left part shift by 32, which yields 0, so x is returned intact.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/mips_alu_exec_if.sv
// Operand/result bundle between the controller/forwarding side (master) and
// the EX-stage ALU (slave).
interface mips_alu_exec_if;
  logic [4:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rs_field;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] pc_plus4;
  logic [31:0] offset;
  logic [31:0] alu_result;
  logic        zero;
  logic [63:0] mult_result;
  logic        hilo_write;
  logic        mul_sel;
  logic [31:0] branch_target;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output alu_op, funct, shamt, rs_field, op_a, op_b, pc_plus4, offset,
    input  alu_result, zero, mult_result, hilo_write, mul_sel, branch_target, hi, lo
  );

  modport slave (
    input  alu_op, funct, shamt, rs_field, op_a, op_b, pc_plus4, offset,
    output alu_result, zero, mult_result, hilo_write, mul_sel, branch_target, hi, lo
  );
endinterface

// File: rtl/mips_alu_exec_dec.sv
// ALU-control decode: {alu_op, funct, shamt, rs_field[0]} -> internal op.
// Macro ALU_MADD_EN enables the SPECIAL2 madd/msub encodings.
module alu_control_dec
  import mips_alu_pkg::*;
(
  input  logic [4:0] alu_op_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] shamt_i,
  input  logic       rs0_i,
  output alu_op_e    op_o,
  output logic       hilo_write_o,
  output logic       mul_sel_o
);

  // Table decode; anything not listed falls through to OP_NONE.
  always_comb begin
    op_o = OP_NONE;
    case (alu_op_i)
      ALUOP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU: op_o = OP_ADD;
          FN_SUB, FN_SUBU: op_o = OP_SUB;
          FN_AND:          op_o = OP_AND;
          FN_OR:           op_o = OP_OR;
          FN_XOR:          op_o = OP_XOR;
          FN_NOR:          op_o = OP_NOR;
          FN_SLT:          op_o = OP_SLT;
          FN_SLTU:         op_o = OP_SLTU;
          FN_SLL:          op_o = OP_SLL;
          FN_SRL:          op_o = rs0_i ? OP_ROTR : OP_SRL;
          FN_SRA:          op_o = OP_SRA;
          FN_SLLV:         op_o = OP_SLLV;
          FN_SRLV:         op_o = shamt_i[0] ? OP_ROTRV : OP_SRLV;
          FN_SRAV:         op_o = OP_SRAV;
          FN_MOVZ, FN_MOVN: op_o = OP_PASSA;
          FN_MULT:         op_o = OP_MULT;
          FN_MULTU:        op_o = OP_MULTU;
          FN_MFHI:         op_o = OP_MFHI;
          FN_MFLO:         op_o = OP_MFLO;
          FN_MTHI:         op_o = OP_MTHI;
          FN_MTLO:         op_o = OP_MTLO;
          FN_JR:           op_o = OP_NONE;
          default:         op_o = OP_NONE;
        endcase
      end
      ALUOP_ADD:  op_o = OP_ADD;
      ALUOP_AND:  op_o = OP_AND;
      ALUOP_OR:   op_o = OP_OR;
      ALUOP_XOR:  op_o = OP_XOR;
      ALUOP_SLT:  op_o = OP_SLT;
      ALUOP_SLTU: op_o = OP_SLTU;
      ALUOP_LUI:  op_o = OP_LUI;
      ALUOP_SPECIAL2: begin
        case (funct_i)
          F2_MUL:  op_o = OP_MUL;
`ifdef ALU_MADD_EN
          F2_MADD: op_o = OP_MADD;
          F2_MSUB: op_o = OP_MSUB;
`endif
          default: op_o = OP_NONE;
        endcase
      end
      ALUOP_SEXT: begin
        if (shamt_i == SEL_SEB) begin
          op_o = OP_SEB;
        end else if (shamt_i == SEL_SEH) begin
          op_o = OP_SEH;
        end else begin
          op_o = OP_NONE;
        end
      end
      ALUOP_SUB:  op_o = OP_SUB;
      default:    op_o = OP_NONE;
    endcase
    hilo_write_o = op_o inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO};
    mul_sel_o    = (op_o == OP_MUL);
  end

endmodule

// File: rtl/mips_alu_exec.sv
// EX-stage ALU, branch-target adder and HI/LO pair of the 5-stage MIPS pipeline.
// Macro ALU_MADD_EN (handled in alu_control_dec) enables madd/msub.
module mips_alu_exec
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic            Clk,
  input  logic            Reset,
  mips_alu_exec_if.slave  bus
);

  alu_op_e              op_s;
  logic                 hilo_write_s;
  logic                 mul_sel_s;
  logic                 sgn_s;
  logic [2*WIDTH-1:0]   a_ext_s;
  logic [2*WIDTH-1:0]   b_ext_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     result_s;
  logic [2*WIDTH-1:0]   hilo_d;
  logic [2*WIDTH-1:0]   hilo_q;
  logic                 unused_rs_s;

  alu_control_dec u_dec (
    .alu_op_i     (bus.alu_op),
    .funct_i      (bus.funct),
    .shamt_i      (bus.shamt),
    .rs0_i        (bus.rs_field[0]),
    .op_o         (op_s),
    .hilo_write_o (hilo_write_s),
    .mul_sel_o    (mul_sel_s)
  );

  assign unused_rs_s = ^bus.rs_field[4:1];

  // Only multu is unsigned; a 64x64 product of the extended operands gives both forms.
  assign sgn_s   = (op_s != OP_MULTU);
  assign a_ext_s = {{WIDTH{sgn_s & bus.op_a[WIDTH-1]}}, bus.op_a};
  assign b_ext_s = {{WIDTH{sgn_s & bus.op_b[WIDTH-1]}}, bus.op_b};
  assign prod_s  = a_ext_s * b_ext_s;

  // Main ALU datapath.
  always_comb begin
    result_s = '0;
    case (op_s)
      OP_ADD:   result_s = bus.op_a + bus.op_b;
      OP_SUB:   result_s = bus.op_a - bus.op_b;
      OP_AND:   result_s = bus.op_a & bus.op_b;
      OP_OR:    result_s = bus.op_a | bus.op_b;
      OP_XOR:   result_s = bus.op_a ^ bus.op_b;
      OP_NOR:   result_s = ~(bus.op_a | bus.op_b);
      OP_SLT:   result_s = {31'd0, $signed(bus.op_a) < $signed(bus.op_b)};
      OP_SLTU:  result_s = {31'd0, bus.op_a < bus.op_b};
      OP_SLL:   result_s = bus.op_b << bus.shamt;
      OP_SRL:   result_s = bus.op_b >> bus.shamt;
      OP_ROTR:  result_s = rotr32(bus.op_b, bus.shamt);
      OP_SRA:   result_s = $unsigned($signed(bus.op_b) >>> bus.shamt);
      OP_SLLV:  result_s = bus.op_b << bus.op_a[4:0];
      OP_SRLV:  result_s = bus.op_b >> bus.op_a[4:0];
      OP_ROTRV: result_s = rotr32(bus.op_b, bus.op_a[4:0]);
      OP_SRAV:  result_s = $unsigned($signed(bus.op_b) >>> bus.op_a[4:0]);
      OP_PASSA: result_s = bus.op_a;
      OP_MFHI:  result_s = hilo_q[2*WIDTH-1:WIDTH];
      OP_MFLO:  result_s = hilo_q[WIDTH-1:0];
      OP_LUI:   result_s = {bus.op_b[15:0], 16'h0000};
      OP_MUL:   result_s = prod_s[WIDTH-1:0];
      OP_SEB:   result_s = {{24{bus.op_b[7]}}, bus.op_b[7:0]};
      OP_SEH:   result_s = {{16{bus.op_b[15]}}, bus.op_b[15:0]};
      default:  result_s = '0;
    endcase
  end

  // Next HI/LO value for the accumulate and move-to ops.
  always_comb begin
    hilo_d = hilo_q;
    case (op_s)
      OP_MULT, OP_MULTU: hilo_d = prod_s;
      OP_MADD:           hilo_d = hilo_q + prod_s;
      OP_MSUB:           hilo_d = hilo_q - prod_s;
      OP_MTHI:           hilo_d = {bus.op_a, hilo_q[WIDTH-1:0]};
      OP_MTLO:           hilo_d = {hilo_q[2*WIDTH-1:WIDTH], bus.op_a};
      default:           hilo_d = hilo_q;
    endcase
  end

  // HI/LO storage; reset clears it even in the middle of an accumulate sequence.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hilo_q <= '0;
    end else if (hilo_write_s) begin
      hilo_q <= hilo_d;
    end else begin
      hilo_q <= hilo_q;
    end
  end

  assign bus.alu_result    = result_s;
  assign bus.zero          = (result_s == 32'd0);
  assign bus.mult_result   = prod_s;
  assign bus.hilo_write    = hilo_write_s;
  assign bus.mul_sel       = mul_sel_s;
  assign bus.branch_target = bus.pc_plus4 + {bus.offset[29:0], 2'b00};
  assign bus.hi            = hilo_q[2*WIDTH-1:WIDTH];
  assign bus.lo            = hilo_q[WIDTH-1:0];

endmodule

// File: tb/tb_mips_alu_exec.sv
// Directed-vector bench for mips_alu_exec: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_mips_alu_exec;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        hw;
    logic        ms;
    bit          chk_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chk_bt;
    logic [31:0] bt;
    bit          chk_pr;
    logic [63:0] pr;
  } exp_t;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;
  exp_t q[$];
  exp_t cur;

  mips_alu_exec_if bus ();

  mips_alu_exec dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued entry is a result.
  always @(negedge Clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "alu_result", {32'd0, bus.alu_result}, {32'd0, e.res});
      chk(e.name, "zero",       {63'd0, bus.zero},       {63'd0, (e.res == 32'd0)});
      chk(e.name, "hilo_write", {63'd0, bus.hilo_write}, {63'd0, e.hw});
      chk(e.name, "mul_sel",    {63'd0, bus.mul_sel},    {63'd0, e.ms});
      if (e.chk_hl) begin
        chk(e.name, "hi", {32'd0, bus.hi}, {32'd0, e.hi});
        chk(e.name, "lo", {32'd0, bus.lo}, {32'd0, e.lo});
      end
      if (e.chk_bt) chk(e.name, "branch_target", {32'd0, bus.branch_target}, {32'd0, e.bt});
      if (e.chk_pr) chk(e.name, "mult_result", bus.mult_result, e.pr);
    end
  end

  task automatic drive(input string nm, input logic [4:0] aop, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [4:0] rs,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic hw, input logic ms);
    @(posedge Clk);
    #1;
    bus.alu_op = aop; bus.funct = fn; bus.shamt = sh; bus.rs_field = rs;
    bus.op_a = a; bus.op_b = b;
    cur = '{name: nm, res: res, hw: hw, ms: ms, chk_hl: 1'b0, hi: 32'd0, lo: 32'd0,
            chk_bt: 1'b0, bt: 32'd0, chk_pr: 1'b0, pr: 64'd0};
  endtask

  task automatic exp_hl(input logic [31:0] h, input logic [31:0] l);
    cur.chk_hl = 1'b1; cur.hi = h; cur.lo = l;
  endtask

  task automatic send();
    q.push_back(cur);
  endtask

  localparam bit MADD = `ifdef ALU_MADD_EN 1'b1 `else 1'b0 `endif;

  initial begin
    errors = 0;
    checks = 0;
    Reset = 1'b0;
    bus.alu_op = 5'd0; bus.funct = 6'd0; bus.shamt = 5'd0; bus.rs_field = 5'd0;
    bus.op_a = 32'd0; bus.op_b = 32'd0; bus.pc_plus4 = 32'd0; bus.offset = 32'd0;

    drive("reset", 5'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    exp_hl(32'd0, 32'd0); send();
    drive("sub_eq", 5'd0, 6'h22, 5'd0, 5'd0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    Reset = 1'b1;
    exp_hl(32'd0, 32'd0); send();
    drive("slt", 5'd0, 6'h2A, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0); send();
    drive("sltu", 5'd0, 6'h2B, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0); send();
    drive("rotr", 5'd0, 6'h02, 5'd4, 5'd1, 32'd0, 32'h0000000F, 32'hF0000000, 1'b0, 1'b0); send();
    drive("srl", 5'd0, 6'h02, 5'd4, 5'd0, 32'd0, 32'h0000000F, 32'h00000000, 1'b0, 1'b0); send();
    drive("sll0", 5'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0); send();
    drive("sra", 5'd0, 6'h03, 5'd4, 5'd0, 32'd0, 32'h80000000, 32'hF8000000, 1'b0, 1'b0); send();
    drive("srav31", 5'd0, 6'h07, 5'd0, 5'd0, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0); send();
    drive("rotrv", 5'd0, 6'h06, 5'd1, 5'd0, 32'd8, 32'h000000FF, 32'hFF000000, 1'b0, 1'b0); send();
    drive("sllv", 5'd0, 6'h04, 5'd0, 5'd0, 32'h00000024, 32'd1, 32'h00000010, 1'b0, 1'b0); send();
    drive("nor", 5'd0, 6'h27, 5'd0, 5'd0, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0, 1'b0); send();
    drive("addi_wrap", 5'd1, 6'h00, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1'b0); send();
    drive("sltiu", 5'd6, 6'h00, 5'd0, 5'd0, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0); send();
    drive("br_sub", 5'd10, 6'h00, 5'd0, 5'd0, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0); send();
    drive("movn", 5'd0, 6'h0B, 5'd0, 5'd0, 32'h0000CAFE, 32'd0, 32'h0000CAFE, 1'b0, 1'b0); send();
    drive("jr", 5'd0, 6'h08, 5'd0, 5'd0, 32'h00000123, 32'd0, 32'd0, 1'b0, 1'b0); send();
    drive("unlisted", 5'd15, 6'h20, 5'd0, 5'd0, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0); send();
    drive("seh", 5'd9, 6'h00, 5'h18, 5'd0, 32'd0, 32'h00008001, 32'hFFFF8001, 1'b0, 1'b0); send();
    drive("seb", 5'd9, 6'h00, 5'h10, 5'd0, 32'd0, 32'h00000080, 32'hFFFFFF80, 1'b0, 1'b0); send();
    drive("sext_bad", 5'd9, 6'h00, 5'h05, 5'd0, 32'd0, 32'h00000080, 32'd0, 1'b0, 1'b0); send();
    drive("lui", 5'd7, 6'h00, 5'd0, 5'd0, 32'd0, 32'h00001234, 32'h12340000, 1'b0, 1'b0); send();
    drive("mul", 5'd8, 6'h02, 5'd0, 5'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1'b0, 1'b1);
    cur.chk_pr = 1'b1; cur.pr = 64'hFFFFFFFF_FFFFFFFA; exp_hl(32'd0, 32'd0); send();

    drive("mult", 5'd0, 6'h18, 5'd0, 5'd0, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b1, 1'b0);
    cur.chk_pr = 1'b1; cur.pr = 64'hFFFFFFFF_FFFFFFFA; exp_hl(32'd0, 32'd0); send();
    drive("mfhi", 5'd0, 6'h10, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    exp_hl(32'hFFFFFFFF, 32'hFFFFFFFA); send();
    drive("madd", 5'd8, 6'h00, 5'd0, 5'd0, 32'd2, 32'd3, 32'd0, MADD, 1'b0);
    cur.chk_pr = 1'b1; cur.pr = 64'd6; exp_hl(32'hFFFFFFFF, 32'hFFFFFFFA); send();
    if (MADD) begin
      drive("mflo_madd", 5'd0, 6'h12, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      exp_hl(32'd0, 32'd0); send();
    end else begin
      drive("mflo_madd", 5'd0, 6'h12, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFA, 1'b0, 1'b0);
      exp_hl(32'hFFFFFFFF, 32'hFFFFFFFA); send();
    end
    drive("msub", 5'd8, 6'h04, 5'd0, 5'd0, 32'd2, 32'd3, 32'd0, MADD, 1'b0); send();
    drive("mfhi_msub", 5'd0, 6'h10, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    exp_hl(32'hFFFFFFFF, 32'hFFFFFFFA); send();

    drive("multu", 5'd0, 6'h19, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 1'b0);
    cur.chk_pr = 1'b1; cur.pr = 64'h00000001_FFFFFFFE; send();
    drive("mflo", 5'd0, 6'h12, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b0);
    exp_hl(32'h00000001, 32'hFFFFFFFE); send();
    drive("mthi", 5'd0, 6'h11, 5'd0, 5'd0, 32'h12345678, 32'd0, 32'd0, 1'b1, 1'b0); send();
    drive("mtlo", 5'd0, 6'h13, 5'd0, 5'd0, 32'h9ABCDEF0, 32'd0, 32'd0, 1'b1, 1'b0);
    exp_hl(32'h12345678, 32'hFFFFFFFE); send();
    drive("mflo_mt", 5'd0, 6'h12, 5'd0, 5'd0, 32'd0, 32'd0, 32'h9ABCDEF0, 1'b0, 1'b0);
    exp_hl(32'h12345678, 32'h9ABCDEF0); send();

    // Asynchronous clear mid-cycle; combinational paths keep working under reset.
    drive("reset_mid", 5'd0, 6'h10, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    bus.pc_plus4 = 32'h00400004; bus.offset = 32'hFFFFFFFF;
    exp_hl(32'd0, 32'd0); cur.chk_bt = 1'b1; cur.bt = 32'h00400000; send();
    drive("bt_wrap", 5'd1, 6'h00, 5'd0, 5'd0, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0);
    Reset = 1'b1;
    bus.pc_plus4 = 32'hFFFFFFFC; bus.offset = 32'h00000001;
    cur.chk_bt = 1'b1; cur.bt = 32'h00000000; exp_hl(32'd0, 32'd0); send();

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue_left=%0d expected=0", q.size());
    end
    @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
